// File: rtl/flop_fifo_if.sv
// Push/pop handshake and data bundle between a producer and a flop_fifo.
// The producer uses the master modport; the FIFO uses the slave modport.
interface flop_fifo_if #(
  parameter int unsigned bits = 16
);
  logic [bits-1:0] Din;
  logic [bits-1:0] Dout;
  logic            push;
  logic            pop;
  logic            full;
  logic            pndng;

  modport master (
    output Din, push, pop,
    input  Dout, full, pndng
  );

  modport slave (
    input  Din, push, pop,
    output Dout, full, pndng
  );
endinterface

// File: rtl/flop_fifo.sv
// Single-clock first-word-fall-through FIFO built from a flip-flop array.
// Depth need not be a power of two; pointers wrap explicitly at depth-1.
module flop_fifo #(
  parameter int unsigned depth = 8,
  parameter int unsigned bits  = 16
) (
  input logic         clk,
  input logic         rst,
  flop_fifo_if.slave  bus
);

  localparam int unsigned CW = $clog2(depth + 1);
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full_c;
  logic            pndng_c;
  logic            push_ok_c;
  logic            pop_ok_c;
  logic [PW-1:0]   wr_ptr_nxt_c;
  logic [PW-1:0]   rd_ptr_nxt_c;
  logic [CW-1:0]   count_nxt_c;

  // Status derived straight from the occupancy counter.
  assign full_c  = (count == CW'(depth));
  assign pndng_c = (count != '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    pop_ok_c  = 1'b0;
    push_ok_c = 1'b0;
    pop_ok_c  = bus.pop && pndng_c;
    push_ok_c = bus.push && (!full_c || pop_ok_c);
  end

  // Next pointer and counter values with explicit wrap at depth-1.
  always_comb begin
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = count;

    if (push_ok_c) begin
      wr_ptr_nxt_c = (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + PW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_nxt_c = (rd_ptr == PW'(depth - 1)) ? '0 : rd_ptr + PW'(1);
    end

    unique case ({push_ok_c, pop_ok_c})
      2'b10:   count_nxt_c = count + CW'(1);
      2'b01:   count_nxt_c = count - CW'(1);
      default: count_nxt_c = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt_c;
      rd_ptr <= rd_ptr_nxt_c;
      count  <= count_nxt_c;
    end
  end

  // Storage array; reset wipes every entry so stale data can never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok_c) begin
      mem[wr_ptr] <= bus.Din;
    end
  end

  assign bus.full  = full_c;
  assign bus.pndng = pndng_c;
  assign bus.Dout  = pndng_c ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_flop_fifo.sv
// Bench for flop_fifo: directed scenarios then random traffic, each cycle
// compared against a queue-based model of FIFO behaviour.
module tb_flop_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BITS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [BITS-1:0] model [$];

  always #5 clk = ~clk;

  flop_fifo_if #(.bits(BITS)) bus ();

  flop_fifo #(.depth(DEPTH), .bits(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_outputs(input string tag);
    logic [BITS-1:0] exp_dout;
    logic            exp_full;
    logic            exp_pndng;
    exp_dout  = (model.size() != 0) ? model[0] : '0;
    exp_full  = (model.size() == DEPTH);
    exp_pndng = (model.size() != 0);
    checks++;
    assert (bus.Dout === exp_dout) else begin
      errors++;
      $error("FAIL %s dout observed=%h expected=%h", tag, bus.Dout, exp_dout);
    end
    checks++;
    assert (bus.full === exp_full) else begin
      errors++;
      $error("FAIL %s full observed=%b expected=%b", tag, bus.full, exp_full);
    end
    checks++;
    assert (bus.pndng === exp_pndng) else begin
      errors++;
      $error("FAIL %s pndng observed=%b expected=%b", tag, bus.pndng, exp_pndng);
    end
  endtask

  // Check the visible head against a constant taken from the scenario itself.
  task automatic check_word(input string tag, input logic [BITS-1:0] want);
    checks++;
    assert (bus.Dout === want) else begin
      errors++;
      $error("FAIL %s word observed=%h expected=%h", tag, bus.Dout, want);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic q,
                      input logic [BITS-1:0] d, input string tag);
    bit pop_ok;
    bit push_ok;
    rst      = r;
    bus.push = p;
    bus.pop  = q;
    bus.Din  = d;
    @(posedge clk);
    if (r) begin
      model.delete();
    end else begin
      pop_ok  = q && (model.size() != 0);
      push_ok = p && ((model.size() < DEPTH) || pop_ok);
      if (pop_ok)  void'(model.pop_front());
      if (push_ok) model.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int pct;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.Din  = '0;

    // Reset held two cycles with a push request pending
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, "reset0");
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, "reset1");
    step(1'b0, 1'b0, 1'b0, 16'h0000, "after_reset");

    // Single word
    step(1'b0, 1'b1, 1'b0, 16'h1234, "single_push");
    check_word("single_head", 16'h1234);
    step(1'b0, 1'b0, 1'b1, 16'h0000, "single_pop");
    check_word("single_empty", 16'h0000);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 16'(i), "fill");
    step(1'b0, 1'b1, 1'b0, 16'hDEAD, "overflow");
    for (int i = 1; i <= 8; i++) begin
      check_word("drain_order", 16'(i));
      step(1'b0, 1'b0, 1'b1, 16'h0000, "drain");
    end

    // Underflow then recovery
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, "underflow");
    step(1'b0, 1'b1, 1'b0, 16'hABCD, "post_underflow_push");
    check_word("post_underflow_head", 16'hABCD);
    step(1'b0, 1'b0, 1'b1, 16'h0000, "post_underflow_pop");

    // Push and pop together while empty: only the push takes effect
    step(1'b0, 1'b1, 1'b1, 16'h7777, "pushpop_empty");
    check_word("pushpop_empty_head", 16'h7777);
    step(1'b0, 1'b0, 1'b1, 16'h0000, "pushpop_empty_drain");

    // Steady state at count=3 with pointers wrapping
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i), "prefill3");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 16'h00AA, "steady3");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, "steady3_drain");

    // Simultaneous push/pop while full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0200 + i), "fill_full");
    step(1'b0, 1'b1, 1'b1, 16'h0BEE, "full_pushpop");
    check_word("full_pushpop_head", 16'h0201);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, "full_drain");

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0300 + i), "fill5");
    step(1'b1, 1'b0, 1'b1, 16'h0000, "mid_reset");
    step(1'b0, 1'b1, 1'b0, 16'h5555, "after_mid_reset");
    check_word("after_mid_reset_head", 16'h5555);

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      pct = ((i / 75) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < pct),
           ($urandom_range(0, 99) < (100 - pct)),
           16'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flop_fifo.md
Name: flop_fifo

Overview:
- Synchronous first-in/first-out buffer built from a flip-flop register array, one clock domain.
- Parameterised depth and data width.
- Used as the buffering element between a producer (push side) and a consumer (pop side).
- The head word is always visible on Dout (first-word-fall-through); status flags report full and data-pending.

Parameters:
- depth, 8, number of storage entries; any integer >= 2, not required to be a power of two.
- bits, 16, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- Din  input  bits  write data, captured when a push is accepted.
- push  input  1  write request, sampled at rising clk.
- pop  input  1  read request, sampled at rising clk; removes the current head word.
- Dout  output  bits  current head word (oldest stored entry); 0 when empty.
- full  output  1  high when occupancy == depth.
- pndng  output  1  high when occupancy > 0 (data pending).

Behaviour:
- Internal state:
  - depth x bits register array.
  - Write pointer and read pointer, each 0..depth-1, wrapping from depth-1 to 0.
  - Occupancy counter, 0..depth.
- Reset (rst=1 at rising clk):
  - Pointers and counter go to 0; all array entries are cleared to 0.
  - full=0, pndng=0, Dout=0 from the following cycle.
  - Reset takes priority over push/pop in the same cycle.
  - Reset mid-operation discards all stored data.
- Outputs are combinational from registered state; no output registers:
  - full = (count == depth).
  - pndng = (count != 0).
  - Dout = array[rd_ptr] when pndng=1, else 0.
- Push accepted when push=1 and (count < depth, or pop is also accepted this cycle while full):
  - array[wr_ptr] <= Din; wr_ptr advances with wrap.
- Pop accepted when pop=1 and count > 0:
  - rd_ptr advances with wrap. The popped word is the one on Dout before the edge.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Boundary cases:
  - Push while full without pop: ignored. Data is dropped, no state change, full stays 1.
  - Push while full with pop: both accepted. Count stays depth, full stays 1, head advances.
  - Pop while empty: ignored. Pointers unchanged, Dout stays 0, pndng stays 0.
  - Push and pop while empty: push accepted, pop ignored. Next cycle count=1, Dout=Din written.
  - Pointer wrap-around is transparent; order is strict FIFO across the wrap.
- Latency:
  - A word pushed at edge N appears on Dout after edge N if the FIFO was empty (pndng rises the same edge).
  - Otherwise the word appears once all older words are popped.
- Dout and flags update only at rising edges, or immediately after reset release.
- Datapath:
  - No arithmetic on data; words pass through unmodified.
  - Counter width is ceil(log2(depth+1)).

Test Plan:
- Reset check: hold rst=1 for 2 cycles with push=1, Din=16'hFFFF -> after release full=0, pndng=0, Dout=0, nothing stored.
- Single word: push Din=16'h1234 one cycle -> next cycle pndng=1, full=0, Dout=16'h1234. Pop one cycle -> pndng=0, Dout=0.
- Fill and overflow (depth=8):
  - Push 16'h0001..16'h0008 -> full=1 after the 8th push.
  - Push 16'hDEAD while full -> ignored.
  - Pop 8 times -> Dout sequence 0001..0008, then pndng=0.
- Underflow: pop 3 times on empty FIFO -> pndng=0, Dout=0, no pointer movement. A subsequent push 16'hABCD then pop returns 16'hABCD.
- Simultaneous push/pop:
  - With count=3: push 16'h00AA with pop each cycle for 10 cycles -> count stays 3, outputs remain in FIFO order, pointers wrap.
  - When full: simultaneous push/pop -> full stays 1, head advances.
- Reset mid-operation: fill 5 words, assert rst one cycle with pop=1 -> count=0, pndng=0, Dout=0. A following push 16'h5555 reads back first.
